id_operand_stage: RTL and testbench

ID-stage operand/hazard block with ID/EX pipeline register. Selects each source operand from three places, using the ID forwarding-unit selects `forward_a`/`forward_b`: the register file, the EX/MEM result, or the MEM/WB write-back data. It resolves `beq`/`bne` in ID and detects load-use and branch-operand hazards, then drives stall/flush to IF. It registers the selected operands, immediate and control bundle into ID/EX, inserting bubbles while stalled.

---
 rtl/id_operand_stage.sv | 147 ++++++++++++++
 tb/tb_id_operand_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// ID-stage operand select, branch resolution, hazard stall FSM and ID/EX pipeline register.
// Optional performance counters are enabled by defining ID_PERF_CNT_EN.
module id_operand_stage #(
  parameter int unsigned CTRL_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       rf_rs_data,
  input  logic [31:0]       rf_rt_data,
  input  logic [31:0]       ex_m_result,
  input  logic [31:0]       m_wb_data,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [4:0]        if_id_rs,
  input  logic [4:0]        if_id_rt,
  input  logic [4:0]        if_id_rd,
  input  logic              uses_rt,
  input  logic              is_branch,
  input  logic              branch_ne,
  input  logic [31:0]       if_id_pc_plus4,
  input  logic [31:0]       imm_sext,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_reg_write,
  input  logic [4:0]        id_ex_dst,
  input  logic              ex_m_mem_read,
  input  logic [4:0]        ex_m_rd,
  output logic              stall,
  output logic              flush_if_id,
  output logic              branch_taken,
  output logic [31:0]       branch_target,
  output logic [31:0]       id_ex_rs_data,
  output logic [31:0]       id_ex_rt_data,
  output logic [31:0]       id_ex_imm,
  output logic [4:0]        id_ex_rs,
  output logic [4:0]        id_ex_rt,
  output logic [4:0]        id_ex_rd,
  output logic [CTRL_W-1:0] id_ex_ctrl,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_taken_cnt,
`endif
  output logic              id_ex_valid
);

  typedef enum logic {StRun, StHold} state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] op_a, op_b;
  logic        ex_hit, mem_hit, eq;
  logic [1:0]  need;

  always_comb begin
    case (forward_a)
      2'b01:   op_a = ex_m_result;
      2'b10:   op_a = m_wb_data;
      default: op_a = rf_rs_data;
    endcase
    case (forward_b)
      2'b01:   op_b = ex_m_result;
      2'b10:   op_b = m_wb_data;
      default: op_b = rf_rt_data;
    endcase
  end

  // r0 is never a real destination, so it can never create a hazard.
  assign ex_hit  = (id_ex_dst != 5'd0) &&
                   ((id_ex_dst == if_id_rs) || (uses_rt && (id_ex_dst == if_id_rt)));
  assign mem_hit = (ex_m_rd != 5'd0) &&
                   ((ex_m_rd == if_id_rs) || (uses_rt && (ex_m_rd == if_id_rt)));

  always_comb begin
    need = 2'd0;
    if (is_branch && ex_m_mem_read && mem_hit) need = 2'd1;
    if (is_branch && id_ex_reg_write && !id_ex_mem_read && ex_hit) need = 2'd1;
    if (id_ex_mem_read && ex_hit) need = is_branch ? 2'd2 : 2'd1;
  end

  // In HOLD the hazard inputs are ignored; the stall is unconditional.
  assign stall         = !reset && ((state_q == StHold) || (need != 2'd0));
  assign eq            = (op_a == op_b);
  assign branch_taken  = !reset && !stall && is_branch && (branch_ne ? !eq : eq);
  assign flush_if_id   = branch_taken;
  assign branch_target = if_id_pc_plus4 + {imm_sext[29:0], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      case (state_q)
        StRun: begin
          if (need == 2'd2) begin
            state_q <= StHold;
            cnt_q   <= 2'd1;
          end
        end
        StHold: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_q <= StRun;
        end
        default: begin
          state_q <= StRun;
          cnt_q   <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      id_ex_rs_data <= '0;
      id_ex_rt_data <= '0;
      id_ex_imm     <= '0;
      id_ex_rs      <= '0;
      id_ex_rt      <= '0;
      id_ex_rd      <= '0;
      id_ex_ctrl    <= '0;
      id_ex_valid   <= 1'b0;
    end else begin
      id_ex_rs_data <= op_a;
      id_ex_rt_data <= op_b;
      id_ex_imm     <= imm_sext;
      id_ex_rs      <= if_id_rs;
      id_ex_rt      <= if_id_rt;
      id_ex_rd      <= if_id_rd;
      id_ex_ctrl    <= ctrl_in;
      id_ex_valid   <= 1'b1;
    end
  end

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_taken_cnt <= '0;
    end else begin
      if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (branch_taken && (perf_taken_cnt != 32'hFFFF_FFFF)) begin
        perf_taken_cnt <= perf_taken_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed cases then randomized traffic vs a
// behavioural model. Define ID_PERF_CNT_EN to also check the perf counters.
module tb_id_operand_stage;
  localparam int unsigned CTRL_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       rf_rs_data, rf_rt_data, ex_m_result, m_wb_data;
  logic [1:0]        forward_a, forward_b;
  logic [4:0]        if_id_rs, if_id_rt, if_id_rd;
  logic              uses_rt, is_branch, branch_ne;
  logic [31:0]       if_id_pc_plus4, imm_sext;
  logic [CTRL_W-1:0] ctrl_in;
  logic              id_ex_mem_read, id_ex_reg_write;
  logic [4:0]        id_ex_dst;
  logic              ex_m_mem_read;
  logic [4:0]        ex_m_rd;
  logic              stall, flush_if_id, branch_taken;
  logic [31:0]       branch_target;
  logic [31:0]       id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]        id_ex_rs, id_ex_rt, id_ex_rd;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic              id_ex_valid;
`ifdef ID_PERF_CNT_EN
  logic [31:0]       perf_stall_cnt, perf_taken_cnt;
`endif

  id_operand_stage #(.CTRL_W(CTRL_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .rf_rs_data      (rf_rs_data),
    .rf_rt_data      (rf_rt_data),
    .ex_m_result     (ex_m_result),
    .m_wb_data       (m_wb_data),
    .forward_a       (forward_a),
    .forward_b       (forward_b),
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .if_id_rd        (if_id_rd),
    .uses_rt         (uses_rt),
    .is_branch       (is_branch),
    .branch_ne       (branch_ne),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .imm_sext        (imm_sext),
    .ctrl_in         (ctrl_in),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_reg_write (id_ex_reg_write),
    .id_ex_dst       (id_ex_dst),
    .ex_m_mem_read   (ex_m_mem_read),
    .ex_m_rd         (ex_m_rd),
    .stall           (stall),
    .flush_if_id     (flush_if_id),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .id_ex_rs_data   (id_ex_rs_data),
    .id_ex_rt_data   (id_ex_rt_data),
    .id_ex_imm       (id_ex_imm),
    .id_ex_rs        (id_ex_rs),
    .id_ex_rt        (id_ex_rt),
    .id_ex_rd        (id_ex_rd),
    .id_ex_ctrl      (id_ex_ctrl),
`ifdef ID_PERF_CNT_EN
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_taken_cnt  (perf_taken_cnt),
`endif
    .id_ex_valid     (id_ex_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: remaining forced-stall cycles and the expected ID/EX contents.
  int          hold_left = 0;
  logic [31:0] e_rs_data, e_rt_data, e_imm;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [CTRL_W-1:0] e_ctrl;
  logic        e_valid;
  longint      m_stall_cnt = 0, m_taken_cnt = 0;
  logic        last_stall, last_taken, last_flush;
  logic [31:0] last_target;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return ex_m_result;
    if (sel == 2'd2) return m_wb_data;
    return rf;
  endfunction

  function automatic bit reads(input logic [4:0] dst);
    return dst != 0 && (dst == if_id_rs || (uses_rt && dst == if_id_rt));
  endfunction

  function automatic int calc_need();
    int n = 0;
    if (is_branch && ex_m_mem_read && reads(ex_m_rd)) n = 1;
    if (is_branch && id_ex_reg_write && !id_ex_mem_read && reads(id_ex_dst)) n = 1;
    if (id_ex_mem_read && reads(id_ex_dst)) n = is_branch ? 2 : 1;
    return n;
  endfunction

  // Inputs are already applied; check combinational outputs, advance model, check ID/EX.
  task automatic step();
    bit          m_stall, m_taken;
    logic [31:0] a, b, tgt;
    int          need;
    #1;
    a   = pick(forward_a, rf_rs_data);
    b   = pick(forward_b, rf_rt_data);
    tgt = if_id_pc_plus4 + imm_sext * 32'd4;
    if (reset) begin
      m_stall   = 0;
      hold_left = 0;
    end else if (hold_left > 0) begin
      m_stall = 1;
      hold_left--;
    end else begin
      need    = calc_need();
      m_stall = (need > 0);
      if (need == 2) hold_left = 1;
    end
    m_taken = !reset && !m_stall && is_branch && (branch_ne ? (a != b) : (a == b));
    last_stall = stall; last_taken = branch_taken; last_flush = flush_if_id;
    last_target = branch_target;
    check("stall", stall, m_stall);
    check("branch_taken", branch_taken, m_taken);
    check("flush_if_id", flush_if_id, m_taken);
    check("branch_target", branch_target, tgt);
    if (reset || m_stall) begin
      {e_rs_data, e_rt_data, e_imm, e_rs, e_rt, e_rd, e_ctrl, e_valid} = '0;
    end else begin
      e_rs_data = a; e_rt_data = b; e_imm = imm_sext;
      e_rs = if_id_rs; e_rt = if_id_rt; e_rd = if_id_rd; e_ctrl = ctrl_in; e_valid = 1;
    end
    if (reset) begin
      m_stall_cnt = 0; m_taken_cnt = 0;
    end else begin
      if (m_stall && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (m_taken && m_taken_cnt < 64'hFFFF_FFFF) m_taken_cnt++;
    end
    @(negedge clk);
    check("id_ex_rs_data", id_ex_rs_data, e_rs_data);
    check("id_ex_rt_data", id_ex_rt_data, e_rt_data);
    check("id_ex_imm", id_ex_imm, e_imm);
    check("id_ex_regs", {id_ex_rs, id_ex_rt, id_ex_rd}, {e_rs, e_rt, e_rd});
    check("id_ex_ctrl", id_ex_ctrl, e_ctrl);
    check("id_ex_valid", id_ex_valid, e_valid);
`ifdef ID_PERF_CNT_EN
    check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
    check("perf_taken_cnt", perf_taken_cnt, m_taken_cnt);
`endif
  endtask

  task automatic idle_inputs();
    rf_rs_data = 0; rf_rt_data = 0; ex_m_result = 0; m_wb_data = 0;
    forward_a = 0; forward_b = 0; if_id_rs = 0; if_id_rt = 0; if_id_rd = 0;
    uses_rt = 0; is_branch = 0; branch_ne = 0; if_id_pc_plus4 = 0; imm_sext = 0;
    ctrl_in = 0; id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_dst = 0;
    ex_m_mem_read = 0; ex_m_rd = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clk);
    step();
    step();
    check("reset_valid", id_ex_valid, 1'b0);
    check("reset_rs_data", id_ex_rs_data, 32'h0);
    reset = 0;

    // Forwarding: EX/MEM result on A, reserved select on B passes the register file.
    forward_a = 2'b01; ex_m_result = 32'h1234; rf_rs_data = 32'hFFFF;
    forward_b = 2'b11; rf_rt_data = 32'hABCD; ctrl_in = 12'h5A5; if_id_rd = 5'd9;
    step();
    check("after_reset_stall", last_stall, 1'b0);
    check("fwd_a_ex_m", id_ex_rs_data, 32'h1234);
    check("fwd_b_reserved", id_ex_rt_data, 32'hABCD);

    // Load-use on a non-branch: exactly one bubble.
    idle_inputs();
    if_id_rs = 5'd5; id_ex_mem_read = 1; id_ex_dst = 5'd5; ctrl_in = 12'h00F;
    step();
    check("ld_use_stall", last_stall, 1'b1);
    check("ld_use_bubble", id_ex_valid, 1'b0);
    id_ex_mem_read = 0;
    step();
    check("ld_use_release", last_stall, 1'b0);
    check("ld_use_valid", id_ex_valid, 1'b1);

    // beq on a load result in EX: two stall cycles, no redirect while stalled.
    idle_inputs();
    is_branch = 1; if_id_rs = 5'd3; id_ex_mem_read = 1; id_ex_dst = 5'd3;
    step();
    check("beq_ld_stall0", last_stall, 1'b1);
    check("beq_ld_taken0", last_taken, 1'b0);
    id_ex_mem_read = 0; id_ex_dst = 0;
    step();
    check("beq_ld_stall1", last_stall, 1'b1);
    check("beq_ld_taken1", last_taken, 1'b0);
    step();
    check("beq_ld_release", last_stall, 1'b0);
    check("beq_taken_after", last_taken, 1'b1);
`ifdef ID_PERF_CNT_EN
    check("perf_three_stalls", perf_stall_cnt, 32'd3);
`endif

    // bne: equal operands not taken, unequal taken to PC+4-4.
    idle_inputs();
    is_branch = 1; branch_ne = 1; uses_rt = 1; if_id_rs = 5'd1; if_id_rt = 5'd2;
    rf_rs_data = 7; rf_rt_data = 7; if_id_pc_plus4 = 32'h100; imm_sext = 32'hFFFF_FFFF;
    step();
    check("bne_eq_not_taken", last_taken, 1'b0);
    rf_rt_data = 8;
    step();
    check("bne_ne_taken", last_taken, 1'b1);
    check("bne_flush", last_flush, 1'b1);
    check("bne_target", last_target, 32'hFC);

    // r0 as a destination never triggers a hazard.
    idle_inputs();
    uses_rt = 1; if_id_rt = 5'd0; id_ex_mem_read = 1; id_ex_dst = 5'd0;
    step();
    check("r0_no_stall", last_stall, 1'b0);

    // Randomized traffic with a narrow register range to make hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 99) < 2);
      if_id_rs        = 5'($urandom_range(0, 3));
      if_id_rt        = 5'($urandom_range(0, 3));
      if_id_rd        = 5'($urandom);
      id_ex_dst       = 5'($urandom_range(0, 3));
      ex_m_rd         = 5'($urandom_range(0, 3));
      uses_rt         = 1'($urandom);
      is_branch       = 1'($urandom);
      branch_ne       = 1'($urandom);
      id_ex_mem_read  = ($urandom_range(0, 3) == 0);
      id_ex_reg_write = 1'($urandom);
      ex_m_mem_read   = ($urandom_range(0, 3) == 0);
      forward_a       = 2'($urandom);
      forward_b       = 2'($urandom);
      rf_rs_data      = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2));
      rf_rt_data      = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2));
      ex_m_result     = 32'($urandom_range(0, 2));
      m_wb_data       = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2));
      if_id_pc_plus4  = $urandom;
      imm_sext        = $urandom;
      ctrl_in         = CTRL_W'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
